// File: rtl/stabilizer_row_reducer.sv
`default_nettype none
// ============================================================================
// Module   : stabilizer_row_reducer
// Brief    : One Gaussian-elimination column step over a stabilizer frame,
//            driving an external combinational Pauli row multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module stabilizer_row_reducer #(
  parameter int NUM_QUBIT  = 4,
  parameter int MAX_VECTOR = 2**NUM_QUBIT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_valid,
  input  logic [$clog2(NUM_QUBIT)-1:0] load_idx,
  input  logic [2*NUM_QUBIT-1:0]       load_row_lit,
  input  logic [MAX_VECTOR-1:0]        load_row_ph,
  input  logic                         start,
  input  logic [$clog2(NUM_QUBIT)-1:0] col,
  output logic                         busy,
  output logic                         done,
  output logic                         pivot_found,
  output logic [$clog2(NUM_QUBIT)-1:0] pivot_idx,
  output logic [2*NUM_QUBIT-1:0]       mult_lit1,
  output logic [MAX_VECTOR-1:0]        mult_ph1,
  output logic [2*NUM_QUBIT-1:0]       mult_lit2,
  output logic [MAX_VECTOR-1:0]        mult_ph2,
  input  logic [2*NUM_QUBIT-1:0]       mult_lit_out,
  input  logic [MAX_VECTOR-1:0]        mult_ph_out,
  input  logic [$clog2(NUM_QUBIT)-1:0] rd_idx,
  output logic [2*NUM_QUBIT-1:0]       rd_lit,
  output logic [MAX_VECTOR-1:0]        rd_ph
);

  localparam int c_IDX_W = $clog2(NUM_QUBIT);
  localparam int c_LIT_W = 2 * NUM_QUBIT;
  localparam logic [c_IDX_W-1:0] c_LAST_ROW = c_IDX_W'(NUM_QUBIT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_ELIM   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_LIT_W-1:0]   r_lit [NUM_QUBIT];
  logic [MAX_VECTOR-1:0] r_ph [NUM_QUBIT];
  logic [c_IDX_W-1:0]   r_row;
  logic [c_IDX_W-1:0]   r_col;
  logic [c_IDX_W-1:0]   r_pivot;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_found;

  // Bit 1 of a literal is the X component: set for X and Y, clear for I and Z.
  logic w_row_has_x;
  logic w_elim_write;

  assign w_row_has_x  = r_lit[r_row][{r_col, 1'b1}];
  assign w_elim_write = (r_state == S_ELIM) && (r_row != r_pivot) && w_row_has_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_pivot <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      for (int i = 0; i < NUM_QUBIT; i++) begin
        r_lit[i] <= '0;
        r_ph[i]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            r_lit[load_idx] <= load_row_lit;
            r_ph[load_idx]  <= load_row_ph;
          end
          if (start) begin
            r_col   <= col;
            r_row   <= '0;
            r_found <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_row_has_x) begin
            r_pivot <= r_row;
            r_found <= 1'b1;
            r_row   <= '0;
            r_state <= S_ELIM;
          end else if (r_row == c_LAST_ROW) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_row <= r_row + c_IDX_W'(1);
          end
        end
        S_ELIM: begin
          // Only row r is rewritten in its own cycle, so the operands read
          // combinationally from the frame are always pre-elimination values.
          if (w_elim_write) begin
            r_lit[r_row] <= mult_lit_out;
            r_ph[r_row]  <= mult_ph_out;
          end
          if (r_row == c_LAST_ROW) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_row <= r_row + c_IDX_W'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mult_lit1 = '0;
    mult_ph1  = '0;
    mult_lit2 = '0;
    mult_ph2  = '0;
    if (r_state == S_ELIM) begin
      mult_lit1 = r_lit[r_row];
      mult_ph1  = r_ph[r_row];
      mult_lit2 = r_lit[r_pivot];
      mult_ph2  = r_ph[r_pivot];
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pivot_found = r_found;
  assign pivot_idx   = r_pivot;
  assign rd_lit      = r_lit[rd_idx];
  assign rd_ph       = r_ph[rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_stabilizer_row_reducer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stabilizer_row_reducer
// Brief    : Directed and random column steps checked against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stabilizer_row_reducer;

  logic        clk;
  logic        reset_n;
  logic        load_valid;
  logic [1:0]  load_idx;
  logic [7:0]  load_row_lit;
  logic [15:0] load_row_ph;
  logic        start;
  logic [1:0]  col;
  logic        busy;
  logic        done;
  logic        pivot_found;
  logic [1:0]  pivot_idx;
  logic [7:0]  mult_lit1;
  logic [15:0] mult_ph1;
  logic [7:0]  mult_lit2;
  logic [15:0] mult_ph2;
  logic [7:0]  mult_lit_out;
  logic [15:0] mult_ph_out;
  logic [1:0]  rd_idx;
  logic [7:0]  rd_lit;
  logic [15:0] rd_ph;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]  m_lit [4];
  logic [15:0] m_ph  [4];

  stabilizer_row_reducer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_idx     (load_idx),
    .load_row_lit (load_row_lit),
    .load_row_ph  (load_row_ph),
    .start        (start),
    .col          (col),
    .busy         (busy),
    .done         (done),
    .pivot_found  (pivot_found),
    .pivot_idx    (pivot_idx),
    .mult_lit1    (mult_lit1),
    .mult_ph1     (mult_ph1),
    .mult_lit2    (mult_lit2),
    .mult_ph2     (mult_ph2),
    .mult_lit_out (mult_lit_out),
    .mult_ph_out  (mult_ph_out),
    .rd_idx       (rd_idx),
    .rd_lit       (rd_lit),
    .rd_ph        (rd_ph)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pauli product a*b qubit by qubit (I=0,Z=1,X=2,Y=3); cyclic X->Y->Z gives +i,
  // anticyclic -i. Phase vector flips only when the total power of i is 2.
  function automatic logic [23:0] pmul(input logic [7:0] a, input logic [15:0] pa,
                                       input logic [7:0] b, input logic [15:0] pb);
    int pw;
    int x;
    int y;
    pw = 0;
    for (int q = 0; q < 4; q++) begin
      x = int'(a[2*q +: 2]);
      y = int'(b[2*q +: 2]);
      if (x != 0 && y != 0 && x != y) begin
        if ((x == 2 && y == 3) || (x == 3 && y == 1) || (x == 1 && y == 2)) pw += 1;
        else pw += 3;
      end
    end
    return {a ^ b, pa ^ pb ^ (((pw % 4) == 2) ? 16'hFFFF : 16'h0000)};
  endfunction

  assign {mult_lit_out, mult_ph_out} = pmul(mult_lit1, mult_ph1, mult_lit2, mult_ph2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [7:0] lit, input logic [15:0] ph);
    load_valid = 1'b1; load_idx = idx; load_row_lit = lit; load_row_ph = ph;
    tick();
    load_valid = 1'b0;
    m_lit[idx] = lit;
    m_ph[idx]  = ph;
  endtask

  task automatic check_rows(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      check($sformatf("%s_row%0d_lit", tag, i), 32'(rd_lit), 32'(m_lit[i]));
      check($sformatf("%s_row%0d_ph", tag, i), 32'(rd_ph), 32'(m_ph[i]));
    end
  endtask

  task automatic check_rd(input logic [1:0] idx, input logic [7:0] lit, input logic [15:0] ph,
                          input string tag);
    rd_idx = idx;
    #1;
    check({tag, "_lit"}, 32'(rd_lit), 32'(lit));
    check({tag, "_ph"}, 32'(rd_ph), 32'(ph));
  endtask

  // One column step; disturb pokes start/load while busy, ld0 loads row 0
  // with lit (phase 0) in the same cycle as start.
  task automatic do_step(input logic [1:0] c, input bit disturb, input bit ld0,
                         input logic [7:0] ld_lit, input string tag);
    logic [7:0]  e_lit [4];
    logic [15:0] e_ph  [4];
    bit f;
    int p;
    int lat;
    int cyc;
    int ci;
    ci = int'(c);
    if (ld0) begin
      load_valid = 1'b1; load_idx = 2'd0; load_row_lit = ld_lit; load_row_ph = 16'h0;
      m_lit[0] = ld_lit;
      m_ph[0]  = 16'h0;
    end
    f = 1'b0;
    p = 0;
    for (int r = 0; r < 4; r++)
      if (!f && m_lit[r][2*ci+1]) begin f = 1'b1; p = r; end
    e_lit = m_lit;
    e_ph  = m_ph;
    if (f)
      for (int r = 0; r < 4; r++)
        if (r != p && m_lit[r][2*ci+1])
          {e_lit[r], e_ph[r]} = pmul(m_lit[r], m_ph[r], m_lit[p], m_ph[p]);
    lat = f ? p + 6 : 5;

    start = 1'b1; col = c;
    tick();
    start = 1'b0; load_valid = 1'b0;
    cyc = 1;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 40) begin
      if (disturb && cyc == 2) begin
        start = 1'b1; col = ~c;
        load_valid = 1'b1; load_idx = 2'd3; load_row_lit = 8'hFF; load_row_ph = 16'hFFFF;
      end else begin
        start = 1'b0; load_valid = 1'b0;
      end
      if (f && cyc == p + 2) begin
        check({tag, "_mult_lit1_first"}, 32'(mult_lit1), 32'(m_lit[0]));
        check({tag, "_mult_lit2_pivot"}, 32'(mult_lit2), 32'(m_lit[p]));
        check({tag, "_mult_ph2_pivot"}, 32'(mult_ph2), 32'(m_ph[p]));
      end
      tick();
      cyc++;
    end
    start = 1'b0; load_valid = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_pivot_found"}, 32'(pivot_found), 32'(f));
    if (f) check({tag, "_pivot_idx"}, 32'(pivot_idx), 32'(p));
    check({tag, "_mult_idle_in_done"}, 32'(mult_lit1), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    check({tag, "_pivot_held"}, 32'(pivot_found), 32'(f));
    m_lit = e_lit;
    m_ph  = e_ph;
    check_rows(tag);
  endtask

  initial begin
    reset_n = 1'b0; load_valid = 1'b0; load_idx = '0; load_row_lit = '0; load_row_ph = '0;
    start = 1'b0; col = '0; rd_idx = '0;
    for (int i = 0; i < 4; i++) begin m_lit[i] = '0; m_ph[i] = '0; end
    tick(); tick();
    reset_n = 1'b1;
    tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pivot_found", 32'(pivot_found), 32'd0);
    check("rst_pivot_idx", 32'(pivot_idx), 32'd0);
    check("rst_mult", 32'({mult_lit1, mult_lit2}), 32'd0);
    check("rst_mult_ph", 32'({mult_ph1, mult_ph2}), 32'd0);
    check_rows("rst");

    // Pivot on row 1; only row 2 has X/Y on qubit 0 besides it.
    load(2'd0, 8'h01, 16'h0000);
    load(2'd1, 8'h0A, 16'h0001);
    load(2'd2, 8'h03, 16'h0000);
    load(2'd3, 8'h04, 16'h0000);
    do_step(2'd0, 1'b0, 1'b0, 8'h00, "ex1");
    check_rd(2'd2, 8'h09, 16'h0001, "ex1_r2_const");
    check_rd(2'd0, 8'h01, 16'h0000, "ex1_r0_const");

    // YY * XX = -ZZ: the whole phase vector flips.
    load(2'd0, 8'h0A, 16'h0000);
    load(2'd1, 8'h0F, 16'h0000);
    load(2'd2, 8'h00, 16'h0000);
    load(2'd3, 8'h00, 16'h0000);
    do_step(2'd0, 1'b0, 1'b0, 8'h00, "ex2");
    check_rd(2'd1, 8'h05, 16'hFFFF, "ex2_r1_const");

    // No X/Y on qubit 2 anywhere.
    load(2'd0, 8'h15, 16'h1234);
    load(2'd1, 8'h04, 16'h0000);
    load(2'd2, 8'h1A, 16'h00F0);
    load(2'd3, 8'h00, 16'h8000);
    do_step(2'd2, 1'b0, 1'b0, 8'h00, "nopivot");

    // start/load while busy must be ignored.
    load(2'd0, 8'h02, 16'h0000);
    load(2'd1, 8'h08, 16'h00FF);
    load(2'd2, 8'h0B, 16'h0F00);
    load(2'd3, 8'h28, 16'h0001);
    do_step(2'd1, 1'b1, 1'b0, 8'h00, "disturb");

    // Same-cycle load of row 0 with start: search sees the new row.
    load(2'd1, 8'h03, 16'h0003);
    do_step(2'd0, 1'b0, 1'b1, 8'h02, "ldstart");
    check("ldstart_pivot0", 32'(pivot_idx), 32'd0);

    // Reset in the middle of elimination.
    load(2'd0, 8'h02, 16'h0001);
    load(2'd1, 8'h03, 16'h0002);
    start = 1'b1; col = 2'd0;
    tick();
    start = 1'b0;
    tick(); tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pivot_found", 32'(pivot_found), 32'd0);
    check("midrst_mult", 32'(mult_lit1), 32'd0);
    for (int i = 0; i < 4; i++) begin m_lit[i] = '0; m_ph[i] = '0; end
    check_rows("midrst");
    tick();
    reset_n = 1'b1;
    tick();

    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 4; i++)
        load(2'(i), 8'($urandom), 16'($urandom));
      do_step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0, 8'h00,
              $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
